// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with a watchdog on stuck transactions.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN; the default is data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  localparam int   BE_W  = DATA_W/8;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mreq_t;

  state_t                 state_q, state_d;
  mreq_t                  req_q, req_sel;
  logic                   owner_q, pick;
  logic                   start, done, timeout, busy;
  logic [1:0]             valid;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic                   err_q;

  assign start = (state_q == IDLE) & (if_req | d_req);
  assign busy  = (state_q == ISSUE) | (state_q == WAIT);
  assign done  = ((state_q == ISSUE) & mem_gnt & mem_rvalid) | ((state_q == WAIT) & mem_rvalid);

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_grant <= OWN_I;
    else if (start) last_grant <= pick;
  end

  assign pick = (d_req & if_req) ? ~last_grant : d_req;
`else
  assign pick = d_req;
`endif

  // fetches are always full-word reads
  always_comb begin
    req_sel = '{we: 1'b0, addr: if_addr, wdata: '0, be: '1};
    if (pick == OWN_D) req_sel = '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};
  end

  // a genuine completion in the final watchdog cycle takes precedence over the timeout
  generate
    if (TIMEOUT_CYC > 0) begin : g_wdog
      localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       cnt_q <= '0;
        else if (start) cnt_q <= '0;
        else if (busy)  cnt_q <= cnt_q + CNT_W'(1);
      end

      assign timeout = busy & (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) & ~done;
    end else begin : g_no_wdog
      assign timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (if_req | d_req)   state_d = ISSUE;
      ISSUE:   if (done | timeout)   state_d = RESP;
               else if (mem_gnt)     state_d = WAIT;
      WAIT:    if (done | timeout)   state_d = RESP;
      RESP:                          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == ISSUE);
    valid   = '0;
    if (state_q == RESP) valid[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      owner_q <= OWN_I;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (start) begin
        req_q   <= req_sel;
        owner_q <= pick;
      end
      if (done) begin
        rdata_q[owner_q] <= req_q.we ? '0 : mem_rdata;
      end else if (timeout) begin
        rdata_q[owner_q] <= '0;
        err_q            <= 1'b1;
      end
    end
  end

  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_be    = req_q.be;

  assign if_valid  = valid[OWN_I];
  assign d_valid   = valid[OWN_D];
  assign if_rdata  = rdata_q[OWN_I];
  assign d_rdata   = rdata_q[OWN_D];
  // stalls are masked during reset so every output reads 0 while rst is low
  assign if_stall  = rst & if_req & ~valid[OWN_I];
  assign d_stall   = rst & d_req  & ~valid[OWN_D];
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: bench plays both requesters and the memory,
// predicting each transaction's timing and data from its own grant/latency choices.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, TO = 8;

  logic clk = 1'b0, rst = 1'b0;
  logic          if_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic          if_valid, if_stall, d_valid, d_stall, mem_req, mem_we, err;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int            n_tests = 0, n_fail = 0;
  bit            m_last, m_err, owner;
  logic [DW-1:0] m_rd [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // owner: 1 = data, 0 = fetch
  function automatic bit pick(input bit i, input bit d, input bit last);
`ifdef MEM_ARB_RR_EN
    if (i && d) return ~last;
`else
    if (i && d) return 1'b1;
`endif
    return d;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_outs(input bit vi, input bit vd);
    chk("if_valid", if_valid, vi);
    chk("d_valid",  d_valid,  vd);
    chk("if_stall", if_stall, if_req & ~vi);
    chk("d_stall",  d_stall,  d_req & ~vd);
    chk("err",      err,      m_err);
    chk("if_rdata", if_rdata, m_rd[0]);
    chk("d_rdata",  d_rdata,  m_rd[1]);
  endtask

  task automatic chk_zero();
    chk("z_mem_req", mem_req, 0);   chk("z_mem_we", mem_we, 0);
    chk("z_mem_addr", mem_addr, 0); chk("z_mem_wdata", mem_wdata, 0);
    chk("z_mem_be", mem_be, 0);     chk("z_if_valid", if_valid, 0);
    chk("z_d_valid", d_valid, 0);   chk("z_if_rdata", if_rdata, 0);
    chk("z_d_rdata", d_rdata, 0);   chk("z_if_stall", if_stall, 0);
    chk("z_d_stall", d_stall, 0);   chk("z_err", err, 0);
  endtask

  task automatic idle_cyc();
    mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    chk("idle_mem_req", mem_req, 0);
    chk_outs(0, 0);
  endtask

  task automatic raise_i();
    if_req = 1'b1; if_addr = $urandom;
  endtask

  task automatic raise_d();
    d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
    d_wdata = $urandom; d_be = 4'($urandom_range(1, 15));
  endtask

  task automatic drop_owner();
    if (owner) d_req = 1'b0; else if_req = 1'b0;
  endtask

  // Current cycle is the IDLE cycle in which the request is sampled (cycle 0).
  // g: cycles of grant backpressure, r: cycles from grant to response, to: memory never responds.
  task automatic run_txn(input int g, input int r, input bit to, input logic [DW-1:0] rword, input bit drop);
    bit            own, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;
    int            gc, endc;
    own = pick(if_req, d_req, m_last); m_last = own;
    e_we = own ? d_we : 1'b0; e_addr = own ? d_addr : if_addr;
    e_wdata = d_wdata; e_be = own ? d_be : 4'hF;
    mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    chk("c0_mem_req", mem_req, 0);
    chk_outs(0, 0);
    gc = 1 + g;
    endc = to ? TO : gc + r;
    for (int c = 1; c <= endc; c++) begin
      step();
      mem_gnt    = (c == gc) ? 1'b1 : (c > gc ? 1'($urandom_range(0, 1)) : 1'b0);
      mem_rvalid = (!to && c == endc) ? 1'b1 : (c < gc ? 1'($urandom_range(0, 1)) : 1'b0);
      mem_rdata  = (!to && c == endc) ? rword : $urandom;
      if (drop && c == 2) begin
        if (own) begin d_req = 1'b0; d_addr = $urandom; end
        else begin if_req = 1'b0; if_addr = $urandom; end
      end
      #1;
      chk("mem_req", mem_req, c <= gc);
      if (c <= gc) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", mem_be, e_be);
        if (own) chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk_outs(0, 0);
    end
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (to) m_err = 1'b1;
    m_rd[own] = (to || e_we) ? '0 : rword;
    #1;
    chk("resp_mem_req", mem_req, 0);
    chk_outs(!own, own);
    owner = own;
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      step(); drop_owner();
      if (!if_req && !d_req) begin
        if ($urandom_range(0, 3) == 0) begin idle_cyc(); continue; end
        case ($urandom_range(0, 2))
          0:       raise_i();
          1:       raise_d();
          default: begin raise_i(); raise_d(); end
        endcase
      end else if ($urandom_range(0, 1) == 1) begin
        if (!if_req) raise_i(); else if (!d_req) raise_d();
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, $urandom, $urandom_range(0, 3) == 0);
    end
    step(); if_req = 1'b0; d_req = 1'b0; idle_cyc();
  endtask

  initial begin
    bit exp_own [4];
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    m_last = 1'b0; m_err = 1'b0; owner = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
    #2; chk_zero();
    step(); step(); rst = 1'b1; if_req = 1'b0; d_req = 1'b0; idle_cyc();

    // fetch only, 1-cycle memory
    step(); if_req = 1'b1; if_addr = 32'h100;
    run_txn(0, 1, 1'b0, 32'h0000_0013, 1'b0);
    step(); drop_owner(); idle_cyc();

    // contention: data store goes first, then the fetch
    step(); if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
    run_txn(1, 2, 1'b0, $urandom, 1'b0);
    chk("contend_first", owner, 1);
    step(); drop_owner();
    run_txn(0, 0, 1'b0, $urandom, 1'b0);
    chk("contend_second", owner, 0);
    step(); drop_owner(); idle_cyc();

    // both requesters held across four transactions
`ifdef MEM_ARB_RR_EN
    exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    step(); raise_i(); raise_d();
    for (int k = 0; k < 4; k++) begin
      run_txn($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, $urandom, 1'b0);
      chk("hold_order", owner, exp_own[k]);
      step();
    end
    if_req = 1'b0; d_req = 1'b0; idle_cyc();

    // grant backpressure for 5 cycles
    step(); raise_i();
    run_txn(5, 1, 1'b0, $urandom, 1'b0);
    step(); drop_owner(); idle_cyc();

    rand_phase(40);

    // watchdog: memory never responds
    step(); raise_d();
    run_txn($urandom_range(0, 9), 0, 1'b1, '0, 1'b0);
    step(); drop_owner(); idle_cyc();
    rand_phase(6);

    // asynchronous reset while in WAIT
    step(); raise_i(); mem_gnt = 1'b0; mem_rvalid = 1'b0; #1;
    step(); mem_gnt = 1'b1; #1; chk("rst_issue_req", mem_req, 1);
    step(); mem_gnt = 1'b0; #2;
    rst = 1'b0; #1;
    chk_zero();
    m_err = 1'b0; m_last = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
    step(); rst = 1'b1; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom; #1;
    chk("stale_mem_req", mem_req, 0);
    chk_outs(0, 0);
    step(); mem_rvalid = 1'b0; #1;
    chk_outs(0, 0);
    step(); raise_i();
    run_txn(1, 1, 1'b0, $urandom, 1'b0);
    step(); drop_owner(); idle_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
